// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings (same 5-bit
// values as the combinational ALU, plus UDIV), FSM state enum and flag struct.
// UDIV is only executed when ALU_MC_DIV_EN is defined.
package alu_pkg;

    localparam logic [4:0] OP_AND  = 5'd0;
    localparam logic [4:0] OP_EOR  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_RSB  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_ADC  = 5'd5;
    localparam logic [4:0] OP_SBC  = 5'd6;
    localparam logic [4:0] OP_TST  = 5'd7;
    localparam logic [4:0] OP_CMP  = 5'd8;
    localparam logic [4:0] OP_CMN  = 5'd9;
    localparam logic [4:0] OP_ORR  = 5'd10;
    localparam logic [4:0] OP_MOV  = 5'd11;
    localparam logic [4:0] OP_BIC  = 5'd12;
    localparam logic [4:0] OP_MVN  = 5'd13;
    localparam logic [4:0] OP_NEG  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_UDIV = 5'd20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative engine for alu_mc: shift-add multiplier and (with ALU_MC_DIV_EN)
// restoring divider sharing one step counter and the acc/a/b registers.
// 'start' loads the operands; one bit is processed per cycle for WIDTH
// cycles. 'done' is high during the final step and 'res' then carries the
// value that step produces, so the caller can capture it on that edge.
module alu_mc_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef ALU_MC_DIV_EN
    input  logic             div_mode,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_q;   // product (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0] a_q;     // multiplicand (MUL) or dividend/quotient (DIV)
    logic [WIDTH-1:0] b_q;     // multiplier (MUL) or divisor (DIV)
    logic [WIDTH-1:0] mul_acc_n;

    // One shift-add step: add the multiplicand when the current multiplier bit is set
    always_comb begin
        mul_acc_n = b_q[0] ? (acc_q + a_q) : acc_q;
    end

`ifdef ALU_MC_DIV_EN
    logic             mode_q;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;

    // One restoring step: shift in the next dividend bit, keep the subtraction if no borrow
    always_comb begin
        rem_sh = {acc_q, a_q[WIDTH-1]};
        diff   = {1'b0, rem_sh} - {2'b00, b_q};
        q_bit  = ~diff[WIDTH+1];
        rem_n  = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_n  = {a_q[WIDTH-2:0], q_bit};
    end

    assign res = mode_q ? quo_n : mul_acc_n;
`else
    assign res = mul_acc_n;
`endif

    assign done = busy_q && (cnt_q == CW'(WIDTH - 1));

    // Operand load on start, then one iteration per cycle until the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
`ifdef ALU_MC_DIV_EN
            mode_q <= 1'b0;
`endif
        end else if (start) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            acc_q  <= '0;
            a_q    <= op_a;
            b_q    <= op_b;
`ifdef ALU_MC_DIV_EN
            mode_q <= div_mode;
`endif
        end else if (busy_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
`ifdef ALU_MC_DIV_EN
            if (mode_q) begin
                acc_q <= rem_n;
                a_q   <= quo_n;
            end else begin
                acc_q <= mul_acc_n;
                a_q   <= a_q << 1;
                b_q   <= b_q >> 1;
            end
`else
            acc_q <= mul_acc_n;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
`endif
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU. Single-cycle ops deliver a result one cycle
// after accept; MUL (and UDIV when ALU_MC_DIV_EN is defined) take WIDTH+1.
// Handshake: a request is taken on in_valid && in_ready, a result leaves on
// out_valid && out_ready; result and flags hold while out_valid && !out_ready,
// and in DONE a new request may be taken in the same cycle the result leaves.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero_flag,
    output logic             negative_flag,
    output logic             overflow_flag
);

    import alu_pkg::*;

    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_n, tgt;
    logic             rdy_q;
    logic [WIDTH-1:0] result_q, sc_res, iter_res;
    flags_t           flags_q, sc_flags, iter_flags;
    logic [WIDTH:0]   sum;
    logic             accept, is_mul, is_div, is_iter, iter_done, div_zero;

    assign in_ready = rdy_q && ((state_q == IDLE) || (state_q == DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign is_mul   = (alu_op == OP_MUL);
`ifdef ALU_MC_DIV_EN
    assign is_div   = (alu_op == OP_UDIV);
`else
    assign is_div   = 1'b0;
`endif
    assign is_iter  = is_mul || is_div;

    assign out_valid     = (state_q == DONE);
    assign result        = result_q;
    assign negative_flag = flags_q.n;
    assign zero_flag     = flags_q.z;
    assign carry_out     = flags_q.c;
    assign overflow_flag = flags_q.v;

    // Single-cycle datapath and flags, evaluated on the live request
    always_comb begin
        sum        = '0;
        sc_res     = '0;
        sc_flags   = '0;
        case (alu_op)
            OP_AND, OP_TST: sc_res = operand_a & operand_b;
            OP_EOR:         sc_res = operand_a ^ operand_b;
            OP_ORR:         sc_res = operand_a | operand_b;
            OP_MOV:         sc_res = operand_b;
            OP_BIC:         sc_res = operand_a & ~operand_b;
            OP_MVN:         sc_res = ~operand_b;
            OP_NEG:         sc_res = '0 - operand_a;
            OP_ADD, OP_CMN, OP_ADC: begin
                sum = {1'b0, operand_a} + {1'b0, operand_b}
                    + {{WIDTH{1'b0}}, (alu_op == OP_ADC) ? carry_in : 1'b0};
                sc_res     = sum[MSB:0];
                sc_flags.c = sum[WIDTH];
                sc_flags.v = (operand_a[MSB] == operand_b[MSB]) && (sc_res[MSB] != operand_a[MSB]);
            end
            OP_SUB, OP_CMP, OP_SBC: begin
                // a - b - !cin is a + ~b + cin; plain subtract uses cin = 1
                sum = {1'b0, operand_a} + {1'b0, ~operand_b}
                    + {{WIDTH{1'b0}}, (alu_op == OP_SBC) ? carry_in : 1'b1};
                sc_res     = sum[MSB:0];
                sc_flags.c = sum[WIDTH];
                sc_flags.v = (operand_a[MSB] != operand_b[MSB]) && (sc_res[MSB] != operand_a[MSB]);
            end
            OP_RSB: begin
                sum = {1'b0, operand_b} + {1'b0, ~operand_a} + {{WIDTH{1'b0}}, 1'b1};
                sc_res     = sum[MSB:0];
                sc_flags.c = sum[WIDTH];
                sc_flags.v = (operand_b[MSB] != operand_a[MSB]) && (sc_res[MSB] != operand_b[MSB]);
            end
            default:        sc_res = '0;
        endcase
        sc_flags.n = sc_res[MSB];
        sc_flags.z = (sc_res == '0);
    end

    // Flags for an iterative result; V marks a divide by zero
    always_comb begin
        iter_flags   = '0;
        iter_flags.n = iter_res[MSB];
        iter_flags.z = (iter_res == '0);
        iter_flags.v = div_zero;
    end

    // Destination state for an accepted request
    always_comb begin
        tgt = DONE;
        if (is_mul) begin
            tgt = MUL;
        end else if (is_div) begin
            tgt = DIV;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:     if (accept) state_n = tgt;
            MUL, DIV: if (iter_done) state_n = DONE;
            DONE:     if (out_ready) state_n = accept ? tgt : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // State, ready enable and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rdy_q    <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_n;
            rdy_q   <= 1'b1;
            if (accept && !is_iter) begin
                result_q <= sc_res;
                flags_q  <= sc_flags;
            end else if (iter_done && (state_q == MUL || state_q == DIV)) begin
                result_q <= iter_res;
                flags_q  <= iter_flags;
            end
        end
    end

`ifdef ALU_MC_DIV_EN
    logic dz_q;
    assign div_zero = dz_q;

    // Remember a zero divisor at accept for the V flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_q <= 1'b0;
        end else if (accept) begin
            dz_q <= is_div && (operand_b == '0);
        end
    end
`else
    assign div_zero = 1'b0;
`endif

    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept && is_iter),
`ifdef ALU_MC_DIV_EN
        .div_mode (is_div),
`endif
        .op_a     (operand_a),
        .op_b     (operand_b),
        .done     (iter_done),
        .res      (iter_res)
    );

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32). Expected {result, n, z, c, v} words go into
// exp_q when a request is accepted and are compared when a result fires.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W  = 32;
    localparam int EW = W + 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         carry_in = 1'b0;
    logic [4:0]   alu_op = '0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         in_ready, out_valid, carry_out, zero_flag, negative_flag, overflow_flag;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] r;
        logic [3:0]   f;   // {n, z, c, v}
    } vec_t;
    vec_t vecs[$];

    alu_mc dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_op        (alu_op),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .carry_in      (carry_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .carry_out     (carry_out),
        .zero_flag     (zero_flag),
        .negative_flag (negative_flag),
        .overflow_flag (overflow_flag)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every fired result against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got 0x%0h expected nothing", result);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result_flags", {result, negative_flag, zero_flag, carry_out, overflow_flag}, mon_exp);
            end
        end
    end

    // Driver: present a request, wait (bounded) for acceptance, log expectation
    task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] r, input logic [3:0] f,
                        output int waited);
        alu_op    = op;
        operand_a = a;
        operand_b = b;
        carry_in  = cin;
        in_valid  = 1'b1;
        waited    = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 after %0d cycles expected 1", waited);
        end else begin
            exp_q.push_back({r, f});
        end
        @(posedge clk);
        #1;
    endtask

    // Count cycles from accept until out_valid, noting any in_ready while busy
    task automatic wait_valid(output int lat, output int rdy_seen);
        lat = 1;
        rdy_seen = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int w, lat, rs;
        logic [W-1:0] ra, rb, rr;
        logic [W:0]   s;

        vecs.push_back('{OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 32'h00F0_1200, 4'b0000});
        vecs.push_back('{OP_EOR, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 4'b1000});
        vecs.push_back('{OP_RSB, 32'd3,         32'd10,        1'b0, 32'd7,         4'b0010});
        vecs.push_back('{OP_RSB, 32'd10,        32'd3,         1'b0, 32'hFFFF_FFF9, 4'b1000});
        vecs.push_back('{OP_ADC, 32'hFFFF_FFFF, 32'd0,         1'b1, 32'd0,         4'b0110});
        vecs.push_back('{OP_CMP, 32'h8000_0000, 32'd1,         1'b0, 32'h7FFF_FFFF, 4'b0011});
        vecs.push_back('{OP_CMN, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0,         4'b0111});
        vecs.push_back('{OP_TST, 32'h0000_00F0, 32'h0000_000F, 1'b0, 32'd0,         4'b0100});
        vecs.push_back('{OP_ORR, 32'h1200_0000, 32'h0000_0034, 1'b0, 32'h1200_0034, 4'b0000});
        vecs.push_back('{OP_MOV, 32'h8000_0001, 32'h8000_0001, 1'b0, 32'h8000_0001, 4'b1000});
        vecs.push_back('{OP_BIC, 32'hFFFF_00FF, 32'h0000_00F0, 1'b0, 32'hFFFF_000F, 4'b1000});
        vecs.push_back('{OP_MVN, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 32'hFFFF_0000, 4'b1000});
        vecs.push_back('{OP_NEG, 32'd1,         32'd1,         1'b0, 32'hFFFF_FFFF, 4'b1000});
        vecs.push_back('{5'd16,  32'd5,         32'd5,         1'b0, 32'd0,         4'b0100});
        vecs.push_back('{5'd31,  32'd5,         32'd5,         1'b1, 32'd0,         4'b0100});
        vecs.push_back('{OP_ADD, 32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         4'b0110});
        vecs.push_back('{OP_SBC, 32'd10,        32'd3,         1'b1, 32'd7,         4'b0010});
        vecs.push_back('{OP_SUB, 32'd1,         32'd2,         1'b0, 32'hFFFF_FFFF, 4'b1000});
`ifndef ALU_MC_DIV_EN
        vecs.push_back('{OP_UDIV, 32'd100,      32'd7,         1'b0, 32'd0,         4'b0100});
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {negative_flag, zero_flag, carry_out, overflow_flag}, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_release", in_ready, 1);

        // ADD overflow, one-cycle latency
        out_ready = 1'b1;
        send(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001, w);
        in_valid = 1'b0;
        chk("add_latency", out_valid, 1);
        drain();

        // Back-to-back SUB then SBC
        send(OP_SUB, 32'd5, 32'd5, 1'b0, 32'd0, 4'b0110, w);
        send(OP_SBC, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 4'b1000, w);
        chk("b2b_wait", w, 0);
        chk("b2b_valid", out_valid, 1);
        drain();

        // Vector table, streamed back to back
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].r, vecs[i].f, w);
        end
        drain();

        // MUL with zero low word, latency and busy in_ready
        send(OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd0, 4'b0100, w);
        in_valid = 1'b0;
        wait_valid(lat, rs);
        chk("mul_latency", lat, 33);
        chk("mul_busy_in_ready", rs, 0);
        drain();
        send(OP_MUL, 32'd7, 32'd6, 1'b0, 32'd42, 4'b0000, w);
        drain();

        // Random MULs held valid while busy
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom_range(0, 65535);
            rr = ra * rb;
            send(OP_MUL, ra, rb, 1'b0, rr, {rr[W-1], rr == 0, 2'b00}, w);
        end
        drain();

        // Random ADDs
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            s  = {1'b0, ra} + {1'b0, rb};
            rr = s[W-1:0];
            send(OP_ADD, ra, rb, 1'b0, rr,
                 {rr[W-1], rr == 0, s[W], (ra[W-1] == rb[W-1]) && (rr[W-1] != ra[W-1])}, w);
        end
        drain();

        // Backpressure then simultaneous fire and accept
        out_ready = 1'b0;
        send(OP_ADD, 32'd3, 32'd4, 1'b0, 32'd7, 4'b0000, w);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_result", result, 7);
            chk("bp_flags", {negative_flag, zero_flag, carry_out, overflow_flag}, 0);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(OP_MOV, 32'd9, 32'd9, 1'b0, 32'd9, 4'b0000, w);
        in_valid = 1'b0;
        chk("bp_accept_wait", w, 0);
        chk("mov_next_result", result, 9);
        chk("mov_next_valid", out_valid, 1);
        drain();

        // Reset in the middle of a MUL
        send(OP_MUL, 32'd3, 32'd5, 1'b0, 32'd15, 4'b0000, w);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_result", result, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready_after", in_ready, 1);
        send(OP_EOR, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 32'h0000_000F, 4'b0000, w);
        in_valid = 1'b0;
        chk("midrst_no_stale", out_valid, 1);
        drain();

`ifdef ALU_MC_DIV_EN
        send(OP_UDIV, 32'd100, 32'd7, 1'b0, 32'd14, 4'b0000, w);
        in_valid = 1'b0;
        wait_valid(lat, rs);
        chk("div_latency", lat, 33);
        chk("div_busy_in_ready", rs, 0);
        drain();
        send(OP_UDIV, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 4'b1001, w);
        drain();
`else
        send(OP_UDIV, 32'd100, 32'd7, 1'b0, 32'd0, 4'b0100, w);
        in_valid = 1'b0;
        chk("udiv_off_latency", out_valid, 1);
        drain();
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
